// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename tags.
// Decode reads two sources (committed value or tag reference) and allocates a
// destination tag. The ROB commit port writes values back and releases references.
// Optional feature macro: REGFILE_COMMIT_BYPASS_EN. When it is defined, a read of a
// reference that is committing this cycle returns the committed data directly.
module reg_rename_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int REG_COUNT  = 34,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   output logic                  read_is_ref_1,
   output logic [DATA_WIDTH-1:0] read_data_1,
   input  logic                  read_en_2,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   output logic                  read_is_ref_2,
   output logic [DATA_WIDTH-1:0] read_data_2,
   input  logic                  alloc_en,
   input  logic [ADDR_WIDTH-1:0] alloc_addr,
   input  logic                  alloc_lo_en,
   input  logic [TAG_WIDTH-1:0]  alloc_tag,
   input  logic                  commit_en,
   input  logic [ADDR_WIDTH-1:0] commit_addr,
   input  logic [TAG_WIDTH-1:0]  commit_tag,
   input  logic [DATA_WIDTH-1:0] commit_data,
   input  logic                  commit_lo_en,
   input  logic [DATA_WIDTH-1:0] commit_lo_data,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] ref_count
);

   localparam int LO_IDX = 33;

   typedef struct packed {
      logic                  is_ref;
      logic [DATA_WIDTH-1:0] data;
   } rd_rsp_t;

   logic [DATA_WIDTH-1:0] r_value [REG_COUNT];
   logic [TAG_WIDTH-1:0]  r_tag   [REG_COUNT];
   logic [REG_COUNT-1:0]  r_ref_vld;
   logic [ADDR_WIDTH-1:0] r_cnt;

   logic [DATA_WIDTH-1:0] w_value_nxt [REG_COUNT];
   logic [TAG_WIDTH-1:0]  w_tag_nxt   [REG_COUNT];
   logic [REG_COUNT-1:0]  w_ref_nxt;
   logic [ADDR_WIDTH-1:0] w_inc;
   logic [ADDR_WIDTH-1:0] w_dec;
   logic [ADDR_WIDTH:0]   w_cnt_sum;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   rd_rsp_t               w_rd_1;
   rd_rsp_t               w_rd_2;

   // Source read: zero for disabled / r0 / unimplemented, else tag reference or value.
   function automatic rd_rsp_t read_port(input logic en, input logic [ADDR_WIDTH-1:0] addr);
      rd_rsp_t rsp;
      rsp = '0;
      if (en && addr != '0 && int'(addr) < REG_COUNT) begin
         if (r_ref_vld[addr]) begin
            rsp.is_ref = 1'b1;
            rsp.data   = DATA_WIDTH'(r_tag[addr]);
`ifdef REGFILE_COMMIT_BYPASS_EN
            // Reference retiring right now: hand the consumer the committed value.
            if (commit_lo_en && int'(addr) == LO_IDX && r_tag[addr] == commit_tag) begin
               rsp.is_ref = 1'b0;
               rsp.data   = commit_lo_data;
            end else if (commit_en && commit_addr == addr && r_tag[addr] == commit_tag) begin
               rsp.is_ref = 1'b0;
               rsp.data   = commit_data;
            end
`endif
         end else begin
            rsp.data = r_value[addr];
         end
      end
      return rsp;
   endfunction

   // Both read ports see pre-edge state, so a decode never sees its own rename.
   always_comb begin
      w_rd_1        = read_port(read_en_1, read_addr_1);
      w_rd_2        = read_port(read_en_2, read_addr_2);
      read_is_ref_1 = w_rd_1.is_ref;
      read_data_1   = w_rd_1.data;
      read_is_ref_2 = w_rd_2.is_ref;
      read_data_2   = w_rd_2.data;
   end

   // Next-state per register: commit writes value and releases matching tag,
   // alloc then overrides the reference, flush drops every reference.
   always_comb begin
      w_value_nxt = r_value;
      w_tag_nxt   = r_tag;
      w_ref_nxt   = r_ref_vld;
      w_inc       = '0;
      w_dec       = '0;
      for (int i = 1; i < REG_COUNT; i++) begin
         logic w_cmt_lo;
         logic w_cmt_gp;
         logic w_alloc_hit;
         w_cmt_lo    = commit_lo_en && (i == LO_IDX);
         w_cmt_gp    = commit_en && (commit_addr == ADDR_WIDTH'(i));
         w_alloc_hit = (alloc_en && alloc_addr == ADDR_WIDTH'(i)) ||
                       (alloc_lo_en && i == LO_IDX);
         if (w_cmt_lo) begin
            w_value_nxt[i] = commit_lo_data;
         end else if (w_cmt_gp) begin
            w_value_nxt[i] = commit_data;
         end
         if ((w_cmt_lo || w_cmt_gp) && r_ref_vld[i] && r_tag[i] == commit_tag) begin
            w_ref_nxt[i] = 1'b0;
         end
         if (w_alloc_hit) begin
            w_ref_nxt[i] = 1'b1;
            w_tag_nxt[i] = alloc_tag;
         end
         if (flush) begin
            w_ref_nxt[i] = 1'b0;
            w_tag_nxt[i] = r_tag[i];
         end
         if (w_ref_nxt[i] && !r_ref_vld[i]) w_inc = w_inc + ADDR_WIDTH'(1);
         if (!w_ref_nxt[i] && r_ref_vld[i]) w_dec = w_dec + ADDR_WIDTH'(1);
      end
   end

   // Reference counter: net change per edge, clamped at zero, cleared by flush.
   always_comb begin
      w_cnt_sum = {1'b0, r_cnt} + {1'b0, w_inc};
      if (flush) begin
         w_cnt_nxt = '0;
      end else if (w_cnt_sum < {1'b0, w_dec}) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = ADDR_WIDTH'(w_cnt_sum - {1'b0, w_dec});
      end
   end

   // State registers; async reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_value[i] <= '0;
            r_tag[i]   <= '0;
         end
         r_ref_vld <= '0;
         r_cnt     <= '0;
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            r_value[i] <= w_value_nxt[i];
            r_tag[i]   <= w_tag_nxt[i];
         end
         r_ref_vld <= {w_ref_nxt[REG_COUNT-1:1], 1'b0};
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign ref_count = r_cnt;

endmodule
